// File: rtl/i2s_rx.sv
// Oversampled I2S slave receiver: recovers left/right PCM pairs from bck/ws/sd in the clk domain.
// Optional lock detector compiled in with `define I2S_RX_LOCK_EN; otherwise locked is high out of reset.
module i2s_rx #(
  parameter int SAMPLE_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic                i2s_bck,
  input  logic                i2s_ws,
  input  logic                i2s_sd,
  output logic [SAMPLE_W-1:0] sample_l,
  output logic [SAMPLE_W-1:0] sample_r,
  output logic                sample_valid,
  output logic [5:0]          slot_bits,
  output logic                locked
);

  logic bck_m, bck_s, bck_d;
  logic ws_m, ws_s;
  logic sd_m, sd_s;

  // bck_d is treated as part of the synchronizer so ena toggling cannot fake a rise
  always_ff @(posedge clk) begin
    if (reset) begin
      bck_m <= 1'b0;
      bck_s <= 1'b0;
      bck_d <= 1'b0;
      ws_m  <= 1'b0;
      ws_s  <= 1'b0;
      sd_m  <= 1'b0;
      sd_s  <= 1'b0;
    end else begin
      bck_m <= i2s_bck;
      bck_s <= bck_m;
      bck_d <= bck_s;
      ws_m  <= i2s_ws;
      ws_s  <= ws_m;
      sd_m  <= i2s_sd;
      sd_s  <= sd_m;
    end
  end

  logic                rise, boundary, emit;
  logic                ws_prev, aligned, have_l;
  logic [SAMPLE_W-1:0] sr, hold_l, word;
  logic [5:0]          bitcnt, slot_len;
  logic                lock_next;

  assign rise     = bck_s & ~bck_d;
  assign boundary = rise && (ws_s != ws_prev);
  assign emit     = boundary && aligned && ws_prev && have_l;

  // Bit n of a slot lands at position SAMPLE_W-1-n; bits past the word width fall off
  always_comb begin
    word = sr;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (int'(bitcnt) == SAMPLE_W - 1 - i) word[i] = sd_s;
    end
    slot_len = (bitcnt == 6'd63) ? 6'd63 : bitcnt + 6'd1;
  end

`ifdef I2S_RX_LOCK_EN
  logic [5:0] len_l, len_prev;
  logic [1:0] cons_cnt;
  logic       consistent;

  assign consistent = (len_l == slot_len) && (slot_len == len_prev);
  assign lock_next  = consistent && (cons_cnt != 2'd0);
`else
  assign lock_next  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset || !ena) begin
      ws_prev      <= 1'b0;
      aligned      <= 1'b0;
      have_l       <= 1'b0;
      sr           <= '0;
      hold_l       <= '0;
      bitcnt       <= '0;
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
      slot_bits    <= '0;
      locked       <= 1'b0;
`ifdef I2S_RX_LOCK_EN
      len_l        <= '0;
      len_prev     <= '0;
      cons_cnt     <= '0;
`endif
    end else begin
      sample_valid <= 1'b0;
`ifndef I2S_RX_LOCK_EN
      locked       <= 1'b1;
`endif
      if (rise) begin
        ws_prev <= ws_s;
        if (!boundary) begin
          sr <= word;
          if (bitcnt != 6'd63) bitcnt <= bitcnt + 6'd1;
        end else begin
          // This bit is the LSB of the channel that just ended
          slot_bits <= slot_len;
          sr        <= '0;
          bitcnt    <= '0;
          aligned   <= 1'b1;
          if (aligned && !ws_prev) begin
            hold_l <= word;
            have_l <= 1'b1;
`ifdef I2S_RX_LOCK_EN
            len_l  <= slot_len;
`endif
          end
          if (emit) begin
            have_l <= 1'b0;
            if (lock_next) begin
              sample_l     <= hold_l;
              sample_r     <= word;
              sample_valid <= 1'b1;
            end
`ifdef I2S_RX_LOCK_EN
            len_prev <= slot_len;
            locked   <= lock_next;
            if (!consistent)            cons_cnt <= 2'd0;
            else if (cons_cnt != 2'd2)  cons_cnt <= cons_cnt + 2'd1;
`endif
          end
        end
      end
    end
  end

endmodule
